// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte streams, with packet lock and frame pacing.
// Optional lock timeout in HOLD is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned UART_BPS     = 115200,
   parameter int unsigned CLK_FREQ     = 100_000_000,
   parameter int unsigned FRAME_BITS   = 10,
   parameter int unsigned HOLD_TIMEOUT = 100_000
) (
   input  logic                         sys_clk,
   input  logic                         sys_rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*8-1:0]         req_data,
   input  logic [NUM_REQ-1:0]           req_last,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [7:0]                   pi_data,
   output logic                         pi_flag,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         busy,
   output logic                         timeout_err
);
   localparam int unsigned ID_W         = $clog2(NUM_REQ);
   localparam int unsigned CNT_W        = 20;
   localparam int unsigned FRAME_CYCLES = (CLK_FREQ / UART_BPS) * FRAME_BITS;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [1:0]       state;
   logic [1:0]       next_state;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  pick_id;
   logic [ID_W-1:0]  next_ptr;
   logic [ID_W:0]    scan;
   logic             pick_found;
   logic             lock;
   logic             frame_last;
   logic             hold_expire;
   logic [CNT_W-1:0] frame_cnt;

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      scan       = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         scan = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (scan >= (ID_W+1)'(NUM_REQ)) begin
            scan = scan - (ID_W+1)'(NUM_REQ);
         end
         if (!pick_found && req_valid[scan[ID_W-1:0]]) begin
            pick_found = 1'b1;
            pick_id    = scan[ID_W-1:0];
         end
      end
   end

   assign next_ptr   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
   assign frame_last = (frame_cnt == CNT_W'(FRAME_CYCLES - 1));

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (pick_found) next_state = S_ISSUE;
         S_ISSUE: next_state = S_WAIT;
         S_WAIT: begin
            if (frame_last) begin
               if (!lock)                    next_state = S_IDLE;
               else if (req_valid[grant_id]) next_state = S_ISSUE;
               else                          next_state = S_HOLD;
            end
         end
         S_HOLD: begin
            if (req_valid[grant_id]) next_state = S_ISSUE;
            else if (hold_expire)    next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Acceptance is a pure decode of the registered state and grant
   always_comb begin
      req_ready = '0;
      if (state == S_ISSUE) req_ready[grant_id] = 1'b1;
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         grant_id  <= '0;
         lock      <= 1'b0;
         frame_cnt <= '0;
         pi_data   <= 8'h00;
         pi_flag   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= next_state;
         busy      <= (next_state != S_IDLE);
         pi_flag   <= (state == S_ISSUE);
         frame_cnt <= (state == S_WAIT && !frame_last) ? frame_cnt + CNT_W'(1) : '0;
         case (state)
            S_IDLE:  if (pick_found) grant_id <= pick_id;
            S_ISSUE: begin
               pi_data <= req_data[{grant_id, 3'b000} +: 8];
               lock    <= ~req_last[grant_id];
            end
            S_WAIT:  if (frame_last && !lock) rr_ptr <= next_ptr;
            S_HOLD: begin
               // Only a lock timeout leaves HOLD for IDLE
               if (next_state == S_IDLE) begin
                  lock   <= 1'b0;
                  rr_ptr <= next_ptr;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] hold_cnt;

   assign hold_expire = (state == S_HOLD) && (hold_cnt == CNT_W'(HOLD_TIMEOUT - 1));

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         hold_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         hold_cnt    <= (state == S_HOLD && next_state == S_HOLD) ? hold_cnt + CNT_W'(1) : '0;
         timeout_err <= (state == S_HOLD) && (next_state == S_IDLE);
      end
   end
`else
   assign hold_expire = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule
